// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/ANDN) among requesters.
// Optional per-requester grant counters are enabled with LOGIC_ARB_STATS_EN.
module logic_unit_arbiter #(
    parameter  int REGISTER_LENGTH = 64,
    parameter  int NUM_REQ         = 4,
    localparam int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [2*NUM_REQ-1:0]               req_op_i,
    input  logic [REGISTER_LENGTH*NUM_REQ-1:0] req_a_i,
    input  logic [REGISTER_LENGTH*NUM_REQ-1:0] req_b_i,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic [REGISTER_LENGTH-1:0]         rsp_data_o,
    output logic [ID_W-1:0]                    rsp_id_o,
    output logic                               rsp_zero_o
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]              grant_cnt_o
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ID_W-1:0]            r_rr_ptr;
    logic [ID_W-1:0]            w_gnt_idx;
    logic                       w_found;
    logic                       w_issue_ok;
    logic                       w_accept;
    logic [1:0]                 w_op;
    logic [REGISTER_LENGTH-1:0] w_a;
    logic [REGISTER_LENGTH-1:0] w_b;
    logic [REGISTER_LENGTH-1:0] w_res;
    logic [REGISTER_LENGTH-1:0] r_data;
    logic [ID_W-1:0]            r_id;
    logic                       r_zero;

    // Index arithmetic modulo NUM_REQ, which need not be a power of two.
    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] p,
                                              input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[ID_W-1:0];
    endfunction

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid_i[f_wrap(r_rr_ptr, k)]) begin
                w_found   = 1'b1;
                w_gnt_idx = f_wrap(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(w_gnt_idx) == i) begin
                w_op = req_op_i[2*i +: 2];
                w_a  = req_a_i[i*REGISTER_LENGTH +: REGISTER_LENGTH];
                w_b  = req_b_i[i*REGISTER_LENGTH +: REGISTER_LENGTH];
            end
        end
    end

    always_comb begin
        w_res = '0;
        unique case (w_op)
            2'b00: w_res = w_a & w_b;
            2'b01: w_res = w_a | w_b;
            2'b10: w_res = w_a ^ w_b;
            2'b11: w_res = w_a & ~w_b;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_ok  = (r_state == S_EMPTY) || rsp_ready_i;
        w_accept    = w_found && w_issue_ok;
        req_ready_o = '0;
        if (w_accept) begin
            w_state_nxt            = S_FULL;
            req_ready_o[w_gnt_idx] = 1'b1;
        end else if ((r_state == S_FULL) && rsp_ready_i) begin
            w_state_nxt = S_EMPTY;
        end
    end

    // Data, id and zero flag stay put when the result drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data   <= '0;
            r_id     <= '0;
            r_zero   <= 1'b1;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_data   <= w_res;
            r_id     <= w_gnt_idx;
            r_zero   <= (w_res == '0);
            r_rr_ptr <= f_wrap(w_gnt_idx, 1);
        end
    end

    assign rsp_valid_o = (r_state == S_FULL);
    assign rsp_data_o  = r_data;
    assign rsp_id_o    = r_id;
    assign rsp_zero_o  = r_zero;

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] r_cnt [NUM_REQ];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
        end else if (w_accept && (r_cnt[w_gnt_idx] != 16'hFFFF)) begin
            r_cnt[w_gnt_idx] <= r_cnt[w_gnt_idx] + 16'd1;
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_o[16*i +: 16] = r_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table plus scoreboard-checked sequences.
// Grant counters are checked when LOGIC_ARB_STATS_EN is defined.
module tb_logic_unit_arbiter;

    localparam int NR = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  id;
        logic        zero;
    } res_t;

    typedef struct {
        logic [3:0]  valid;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ready;
        res_t        res;
    } vec_t;

    logic         clk;
    logic         rst_ni;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [1:0]   op [NR];
    logic [63:0]  a [NR];
    logic [63:0]  b [NR];
    logic [7:0]   op_bus;
    logic [255:0] a_bus;
    logic [255:0] b_bus;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_zero;
`ifdef LOGIC_ARB_STATS_EN
    logic [63:0]  grant_cnt;
`endif

    always_comb begin
        op_bus = '0;
        a_bus  = '0;
        b_bus  = '0;
        for (int i = 0; i < NR; i++) begin
            op_bus[2*i +: 2] = op[i];
            a_bus[64*i +: 64] = a[i];
            b_bus[64*i +: 64] = b[i];
        end
    end

    logic_unit_arbiter #(
        .REGISTER_LENGTH(64),
        .NUM_REQ(NR)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_op_i(op_bus),
        .req_a_i(a_bus),
        .req_b_i(b_bus),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data),
        .rsp_id_o(rsp_id),
        .rsp_zero_o(rsp_zero)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .grant_cnt_o(grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t sb_q[$];
    logic m_full;
    int   m_ptr;
    res_t m_res;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] f_op(input logic [1:0] o,
                                         input logic [63:0] x,
                                         input logic [63:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return x & ~y;
        endcase
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        chk("rst valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst data", rsp_data, 64'd0);
        chk("rst id", {62'b0, rsp_id}, 64'd0);
        chk("rst zero", {63'b0, rsp_zero}, 64'd1);
        chk("rst ready", {60'b0, req_ready}, 64'd0);
        m_full = 1'b0;
        m_ptr  = 0;
        m_res  = '{data: 64'd0, id: 2'd0, zero: 1'b1};
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // Called just after a rising edge; drives one cycle and checks both sides.
    task automatic run_cycle(input logic [3:0] v, input logic rdy,
                             input logic use_tbl, input res_t te_res,
                             input logic [3:0] te_rdy, input string tag);
        logic       ok;
        logic       found;
        logic       acc;
        int         g;
        int         idx;
        logic [3:0] exp_rdy;
        res_t       e;
        req_valid = v;
        rsp_ready = rdy;
        @(negedge clk);
        ok    = !m_full || rdy;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (!found && v[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        acc     = found && ok;
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;
        chk({tag, " ready"}, {60'b0, req_ready}, {60'b0, use_tbl ? te_rdy : exp_rdy});
        if (acc) begin
            if (use_tbl) begin
                e = te_res;
            end else begin
                e.data = f_op(op[g], a[g], b[g]);
                e.id   = 2'(g);
                e.zero = (e.data == 64'd0);
            end
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            m_ptr  = (g + 1) % NR;
            m_full = 1'b1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scoreboard: got empty queue, expected entry", tag);
            end else begin
                m_res = sb_q.pop_front();
            end
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        chk({tag, " valid"}, {63'b0, rsp_valid}, {63'b0, m_full});
        chk({tag, " data"}, rsp_data, m_res.data);
        chk({tag, " id"}, {62'b0, rsp_id}, {62'b0, m_res.id});
        chk({tag, " zero"}, {63'b0, rsp_zero}, {63'b0, m_res.zero});
    endtask

    initial begin
        rst_ni    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        m_full    = 1'b0;
        m_ptr     = 0;
        m_res     = '0;
        for (int i = 0; i < NR; i++) begin
            op[i] = '0;
            a[i]  = '0;
            b[i]  = '0;
        end

        tbl[0] = '{4'b0100, 2'b00, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F,
                   4'b0100, '{64'h0F00_0F00_0F00_0F00, 2'd2, 1'b0}};
        tbl[1] = '{4'b0001, 2'b00, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF,
                   4'b0001, '{64'hAAAA_AAAA_AAAA_AAAA, 2'd0, 1'b0}};
        tbl[2] = '{4'b0001, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF,
                   4'b0001, '{64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0}};
        tbl[3] = '{4'b0001, 2'b10, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF,
                   4'b0001, '{64'h5555_5555_5555_5555, 2'd0, 1'b0}};
        tbl[4] = '{4'b0001, 2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF,
                   4'b0001, '{64'h0, 2'd0, 1'b1}};
        tbl[5] = '{4'b0000, 2'b00, 64'h0, 64'h0, 4'b0000, '{64'h0, 2'd0, 1'b1}};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < NR; j++) begin
                op[j] = tbl[i].op;
                a[j]  = tbl[i].a;
                b[j]  = tbl[i].b;
            end
            run_cycle(tbl[i].valid, 1'b1, 1'b1, tbl[i].res, tbl[i].ready,
                      $sformatf("vec%0d", i));
        end

        do_reset();
        for (int i = 0; i < NR; i++) begin
            op[i] = 2'(i);
            a[i]  = {$urandom, $urandom};
            b[i]  = {$urandom, $urandom};
        end
        for (int k = 0; k < 8; k++) begin
            run_cycle(4'hF, 1'b1, 1'b0, '0, '0, $sformatf("rr%0d", k));
            chk("rr order", {62'b0, rsp_id}, 64'(k % NR));
        end

        run_cycle(4'b0001, 1'b1, 1'b0, '0, '0, "bp fill");
        for (int k = 0; k < 5; k++) begin
            run_cycle(4'b0010, 1'b0, 1'b0, '0, '0, $sformatf("bp hold%0d", k));
        end
        run_cycle(4'b0010, 1'b1, 1'b0, '0, '0, "bp release");
        chk("bp new id", {62'b0, rsp_id}, 64'd1);
        run_cycle(4'b0000, 1'b1, 1'b0, '0, '0, "bp drain");

        run_cycle(4'b0001, 1'b1, 1'b0, '0, '0, "mid fill");
        do_reset();
        run_cycle(4'b1000, 1'b1, 1'b0, '0, '0, "post rst");
        chk("post rst id", {62'b0, rsp_id}, 64'd3);
        run_cycle(4'b1001, 1'b1, 1'b0, '0, '0, "post rst2");
        chk("post rst2 id", {62'b0, rsp_id}, 64'd0);

`ifdef LOGIC_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 10; k++) begin
            run_cycle(4'b0010, 1'b1, 1'b0, '0, '0, $sformatf("st%0d", k));
        end
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("cnt%0d", i), {48'b0, grant_cnt[16*i +: 16]},
                (i == 1) ? 64'd10 : 64'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one REGISTER_LENGTH-bit bitwise logic unit (AND / OR / XOR / AND-NOT) among NUM_REQ requesters. Arbitration is round-robin. Operands are captured into a single result register, and results return through a valid/ready response port tagged with the requester ID. The block sits between the issue logic and the shared logic datapath. Each requester sees a pipelined, back-pressurable functional unit.

## Interface
- REGISTER_LENGTH, 64, operand/result width in bits
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden)

- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  NUM_REQ  request pending, one bit per requester
- req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_op_i  in  2*NUM_REQ  op per requester, slice [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 A&~B
- req_a_i  in  REGISTER_LENGTH*NUM_REQ  operand A, slice i
- req_b_i  in  REGISTER_LENGTH*NUM_REQ  operand B, slice i
- rsp_valid_o  out  1  result register holds an unconsumed result
- rsp_ready_i  in  1  consumer takes result this cycle
- rsp_data_o  out  REGISTER_LENGTH  registered result
- rsp_id_o  out  ID_W  index of the requester that produced rsp_data_o
- rsp_zero_o  out  1  rsp_data_o == 0

## Operation
- State machine:
  - EMPTY: rsp_valid_o = 0.
  - FULL: rsp_valid_o = 1, result held.
- issue_ok = EMPTY || rsp_ready_i.
- Grant, combinational:
  - Search req_valid_i starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit wins and becomes gnt_idx.
  - req_ready_o[gnt_idx] = issue_ok; all other bits are 0.
- Accept = any req_valid_i && issue_ok. On accept, at the clock edge:
  - rsp_data_o <= op(A[gnt_idx], B[gnt_idx]).
  - rsp_id_o <= gnt_idx.
  - rsp_zero_o <= (result == 0).
  - rr_ptr <= (gnt_idx + 1) mod NUM_REQ.
  - State becomes FULL.
- In FULL, rsp_ready_i = 1 and no accept: state becomes EMPTY; data, ID and zero flag keep their last values.
- In FULL, rsp_ready_i = 0: all outputs hold stable and every req_ready_o bit is 0.
- Simultaneous consume and accept: the new result replaces the old one in the same edge and the state stays FULL. This gives one result per cycle.
- rr_ptr advances only on accept. An idle cycle does not move it.
- Requesters hold valid, op and operands stable until they see ready. The block does not check this.
- Ops are purely bitwise, with no carry and no width change.

## Timing
- Latency: a request accepted at edge t produces its result on rsp_data_o and rsp_valid_o after edge t, i.e. 1 cycle.
- Throughput: 1 request per cycle while rsp_ready_i = 1.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- req_ready_o depends combinationally on req_valid_i, rsp_ready_i and state. No output depends combinationally on req_a_i or req_b_i.
- Reset values, applied asynchronously:
  - State EMPTY, rsp_valid_o = 0.
  - rsp_data_o = 0, rsp_id_o = 0, rsp_zero_o = 1.
  - rr_ptr = 0.
- Reset asserted mid-transaction drops any held result; nothing is replayed.
- Reset deassertion is synchronous to clk_i externally. The first accept can occur on the first edge after release.

## Configuration
- LOGIC_ARB_STATS_EN defined:
  - Adds output grant_cnt_o (16*NUM_REQ). Slice i is a 16-bit counter of accepts for requester i.
  - Counters increment on accept and saturate at 16'hFFFF.
  - Counters reset to 0.
- LOGIC_ARB_STATS_EN undefined:
  - Port and counters are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then single request: req 2 valid, op 00, A=64'hFF00_FF00_FF00_FF00, B=64'h0F0F_0F0F_0F0F_0F0F, rsp_ready_i=1.
  - Required: ready[2] in cycle 0.
  - Next cycle: rsp_valid_o=1, data=64'h0F00_0F00_0F00_0F00, id=2, zero=0.
- All four requesters valid continuously, rsp_ready_i=1.
  - Required: grant order 0,1,2,3,0,1..., one rsp per cycle, ids matching the grant order.
- Backpressure: a result held with rsp_ready_i=0 for 5 cycles while req 1 is valid.
  - Required: req_ready_o=0 and rsp outputs stable throughout.
  - When rsp_ready_i rises, req 1 is accepted in that same cycle and the new result appears on the next cycle.
- Op coverage on req 0, A=64'hAAAA..., B=64'hFFFF...:
  - AND gives AAAA..., OR gives FFFF..., XOR gives 5555..., A&~B gives 0 with zero=1.
- Reset mid-operation: rst_ni low while FULL.
  - Required: rsp_valid_o=0 and data=0 immediately, without waiting for a clock edge.
  - After release, req 3 alone is granted first (rr_ptr = 0 search).
- With LOGIC_ARB_STATS_EN defined: 10 accepts from req 1.
  - Required: grant_cnt_o slice 1 = 10, other slices 0.
